// File: rtl/muldiv_seq_if.sv
// Handshake and result bundle for muldiv_seq: the requester drives start/op/A/B,
// the unit returns busy/done, the 2*WIDTH result and the divide-by-zero flag.
interface muldiv_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic               start;
  logic               op;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] Zwide;
  logic [WIDTH-1:0]   Zhigh;
  logic [WIDTH-1:0]   Zlow;
  logic               dz;

  modport master (output start, op, A, B,
                  input  busy, done, Zwide, Zhigh, Zlow, dz);
  modport slave  (input  start, op, A, B,
                  output busy, done, Zwide, Zhigh, Zlow, dz);
endinterface

// File: rtl/muldiv_seq.sv
// Sequential signed multiply (radix-2 Booth) / divide (restoring, sign-magnitude) unit.
// Optional macro MULDIV_DIVZERO_EN: short-circuits DIV by zero and raises dz.
module muldiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input logic         clock,
  input logic         clear,
  muldiv_seq_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic             is_div, sign_q, sign_r, qm1;
  logic [WIDTH:0]   a_r, hi;
  logic [WIDTH-1:0] lo, z_hi, z_lo;
  logic             div_zero, fix_wait;
  logic [WIDTH:0]   addend, sum, shifted;
  logic [WIDTH+1:0] diff;

  function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] e;
    e = {v[WIDTH-1], v};
    return v[WIDTH-1] ? -e : e;
  endfunction

`ifdef MULDIV_DIVZERO_EN
  logic dz_pend, dz_r;
  assign div_zero = bus.op && (bus.B == '0);
  // Divide-by-zero spends two edges in FIX so done lands after edge 2.
  assign fix_wait = dz_pend && (count == '0);
  assign bus.dz   = dz_r;
`else
  assign div_zero = 1'b0;
  assign fix_wait = 1'b0;
  assign bus.dz   = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (clear) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = div_zero ? FIX : RUN;
      RUN:  if (count == CW'(WIDTH - 1)) state_nxt = FIX;
      FIX:  if (!fix_wait) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Booth add/subtract on the upper word, and the shift-subtract trial for DIV.
  always_comb begin
    addend = '0;
    case ({lo[0], qm1})
      2'b01:   addend = a_r;
      2'b10:   addend = -a_r;
      default: addend = '0;
    endcase
    sum     = hi + addend;
    shifted = {hi[WIDTH-1:0], lo[WIDTH-1]};
    diff    = {1'b0, shifted} - {1'b0, a_r};
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      count  <= '0;
      is_div <= 1'b0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      qm1    <= 1'b0;
      a_r    <= '0;
      hi     <= '0;
      lo     <= '0;
      z_hi   <= '0;
      z_lo   <= '0;
`ifdef MULDIV_DIVZERO_EN
      dz_pend <= 1'b0;
      dz_r    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          is_div <= bus.op;
          count  <= '0;
          qm1    <= 1'b0;
          hi     <= '0;
          sign_q <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
          sign_r <= bus.A[WIDTH-1];
          if (bus.op) begin
            a_r <= magnitude(bus.B);
            lo  <= bus.A[WIDTH-1] ? -bus.A : bus.A;
          end else begin
            a_r <= {bus.A[WIDTH-1], bus.A};
            lo  <= bus.B;
          end
`ifdef MULDIV_DIVZERO_EN
          dz_pend <= div_zero;
          dz_r    <= 1'b0;
          if (div_zero) hi <= {bus.A[WIDTH-1], bus.A};
`endif
        end
        RUN: begin
          count <= count + CW'(1);
          if (is_div) begin
            if (!diff[WIDTH+1]) begin
              hi <= diff[WIDTH:0];
              lo <= {lo[WIDTH-2:0], 1'b1};
            end else begin
              hi <= shifted;
              lo <= {lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            hi  <= {sum[WIDTH], sum[WIDTH:1]};
            lo  <= {sum[0], lo[WIDTH-1:1]};
            qm1 <= lo[0];
          end
        end
        FIX: begin
`ifdef MULDIV_DIVZERO_EN
          if (fix_wait) count <= count + CW'(1);
          else if (dz_pend) begin
            z_hi <= hi[WIDTH-1:0];
            z_lo <= '1;
            dz_r <= 1'b1;
          end else
`endif
          if (is_div) begin
            z_hi <= sign_r ? -hi[WIDTH-1:0] : hi[WIDTH-1:0];
            z_lo <= sign_q ? -lo : lo;
          end else begin
            z_hi <= hi[WIDTH-1:0];
            z_lo <= lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = (state != IDLE);
  assign bus.done  = (state == DONE);
  assign bus.Zhigh = z_hi;
  assign bus.Zlow  = z_lo;
  assign bus.Zwide = {z_hi, z_lo};
endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized bench for muldiv_seq: transaction-level reference model checked every cycle,
// plus directed operations with literal results and latencies.
module tb_muldiv_seq;
  localparam int unsigned WIDTH = 32;

  logic clock = 1'b0;
  logic clear = 1'b1;
  always #5 clock = ~clock;

  muldiv_seq_if #(.WIDTH(WIDTH)) bus ();
  muldiv_seq #(.WIDTH(WIDTH)) dut (.clock(clock), .clear(clear), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!o) return 64'(sa * sb);
`ifdef MULDIV_DIVZERO_EN
    if (sb == 0) return {a, 32'hFFFF_FFFF};
`else
    if (sb == 0) return '0;
`endif
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Transaction-level model: an accepted request produces its result a fixed
  // number of edges later; anything offered while busy is dropped.
  logic        m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0, m_pdz = 1'b0;
  logic [63:0] m_z = '0, m_pend = '0;
  int          m_t = 0, m_lat = 0;

  always @(posedge clock) begin
    if (clear) begin
      m_busy = 1'b0; m_done = 1'b0; m_z = '0; m_dz = 1'b0;
    end else if (!m_busy) begin
      if (bus.start) begin
        m_busy = 1'b1;
        m_t    = 0;
        m_lat  = WIDTH + 1;
        m_pend = ref_result(bus.op, bus.A, bus.B);
        m_pdz  = 1'b0;
`ifdef MULDIV_DIVZERO_EN
        m_dz = 1'b0;
        if (bus.op && bus.B == '0) begin
          m_lat = 2;
          m_pdz = 1'b1;
        end
`endif
      end
    end else begin
      m_t++;
      if (m_t == m_lat) begin
        m_done = 1'b1; m_z = m_pend; m_dz = m_pdz;
      end else if (m_t == m_lat + 1) begin
        m_busy = 1'b0; m_done = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    chk("busy",  64'(bus.busy),  64'(m_busy));
    chk("done",  64'(bus.done),  64'(m_done));
    chk("dz",    64'(bus.dz),    64'(m_dz));
    chk("Zwide", bus.Zwide,      m_z);
    chk("Zhigh", 64'(bus.Zhigh), 64'(m_z[63:32]));
    chk("Zlow",  64'(bus.Zlow),  64'(m_z[31:0]));
  end

  task automatic run_op(input string name, input logic o, input logic [31:0] a,
                        input logic [31:0] b, input int intrude_at,
                        input bit has_lit, input logic [63:0] lit);
    int cyc, exp_lat;
    exp_lat = WIDTH + 2;
`ifdef MULDIV_DIVZERO_EN
    if (o && b == '0) exp_lat = 3;
`endif
    @(negedge clock);
    bus.start = 1'b1; bus.op = o; bus.A = a; bus.B = b;
    @(negedge clock);
    bus.start = 1'b0;
    cyc = 1;
    while (!bus.done && cyc < 200) begin
      bus.start = (cyc == intrude_at);
      bus.op = 1'($urandom); bus.A = $urandom; bus.B = $urandom;
      @(negedge clock);
      cyc++;
    end
    bus.start = 1'b0;
    chk({name, "_latency"}, 64'(cyc), 64'(exp_lat));
    if (has_lit) chk({name, "_result"}, bus.Zwide, lit);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] corner [5] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'h0};
    if ($urandom_range(3) == 0) return corner[$urandom_range(4)];
    return $urandom;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb;
    logic        ro;
    int          cyc;
    bus.start = 1'b0; bus.op = 1'b0; bus.A = '0; bus.B = '0;
    repeat (2) @(negedge clock);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_Zwide", bus.Zwide, 64'd0);
    clear = 1'b0;

    run_op("mul_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD, 5, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("mul_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 0, 1'b1, 64'h4000_0000_0000_0000);
    run_op("mul_m1_m1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1, 64'h0000_0000_0000_0001);
    run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("div_100_7", 1'b1, 32'd100, 32'd7, 7, 1'b1, 64'h0000_0002_0000_000E);
    run_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1, 64'h0000_0000_8000_0000);
    chk("div_min_m1_dz", 64'(bus.dz), 64'd0);

    // Clear in the middle of a multiply discards it.
    @(negedge clock);
    bus.start = 1'b1; bus.op = 1'b0; bus.A = 32'd123; bus.B = 32'd456;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (9) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    chk("clear_busy", 64'(bus.busy), 64'd0);
    chk("clear_done", 64'(bus.done), 64'd0);
    chk("clear_Zwide", bus.Zwide, 64'd0);
    run_op("after_clear", 1'b0, 32'd123, 32'd456, 0, 1'b1, 64'd56088);

    // Start held high: the second request is taken only after DONE.
    @(negedge clock);
    bus.start = 1'b1; bus.op = 1'b0; bus.A = 32'd5; bus.B = 32'hFFFF_FFFA;
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (!bus.done && cyc < 200);
    chk("b2b_latency", 64'(cyc), 64'(WIDTH + 2));
    chk("b2b_result", bus.Zwide, 64'hFFFF_FFFF_FFFF_FFE2);
    @(negedge clock);
    chk("b2b_idle_gap", 64'(bus.busy), 64'd0);
    @(negedge clock);
    chk("b2b_reaccept", 64'(bus.busy), 64'd1);
    bus.start = 1'b0;
    cyc = 0;
    while (!bus.done && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    chk("b2b_second", bus.Zwide, 64'hFFFF_FFFF_FFFF_FFE2);

`ifdef MULDIV_DIVZERO_EN
    run_op("div_zero", 1'b1, 32'h1234_5678, 32'h0, 0, 1'b1, 64'h1234_5678_FFFF_FFFF);
    chk("div_zero_dz", 64'(bus.dz), 64'd1);
    run_op("mul_after_dz", 1'b0, 32'd3, 32'd4, 0, 1'b1, 64'd12);
    chk("mul_after_dz_flag", 64'(bus.dz), 64'd0);
`endif

    for (int i = 0; i < 50; i++) begin
      ro = 1'($urandom);
      ra = pick();
      rb = pick();
`ifndef MULDIV_DIVZERO_EN
      if (ro && rb == '0) rb = 32'd1;
`endif
      repeat ($urandom_range(3)) @(negedge clock);
      run_op("random", ro, ra, rb, ($urandom_range(3) == 0) ? int'($urandom_range(30, 2)) : 0,
             1'b0, '0);
    end

    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
